fetch_buffer: RTL and testbench

//  Consumer side of the PC/fetch interface: queues {pc, instr} pairs produced by the

---
 rtl/fetch_buffer.sv | 91 +++++++++
 tb/tb_fetch_buffer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Fetch buffer: in-order FIFO of {pc, instr} pairs between fetch and decode.
// Optional zero-latency empty bypass is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_pc,
   input  logic [31:0]   in_instr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_pc,
   output logic [31:0]   out_instr,
   output logic [AW:0]   count
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_q;
   logic          empty, full;
   logic          bypass, store, pop;
   entry_t        head;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL);
   assign in_ready = ~full;
   assign count    = count_q;

`ifdef FETCH_BUF_BYPASS_EN
   // Empty buffer: present the incoming pair directly; it is only stored if decode stalls.
   assign bypass = empty & in_valid & ~flush & ~reset;
   assign store  = in_valid & ~full & ~flush & ~(bypass & out_ready);
`else
   assign bypass = 1'b0;
   assign store  = in_valid & ~full & ~flush;
`endif

   assign pop       = ~empty & out_ready & ~flush;
   assign out_valid = ~empty | bypass;

   always_comb begin
      head = '0;
      if (!empty)
         head = mem[rd_ptr];
      else if (bypass)
         head = '{pc: in_pc, instr: in_instr};
   end

   assign out_pc    = head.pc;
   assign out_instr = head.instr;

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (store)
         mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (store)
            wr_ptr <= AW'(wr_ptr + 1'b1);
         if (pop)
            rd_ptr <= AW'(rd_ptr + 1'b1);
         case ({store, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic, all checked
// against a queue-based reference model.
module tb_fetch_buffer;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_instr, out_pc, out_instr;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;
   logic [63:0] q[$];

`ifdef FETCH_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   fetch_buffer #(.DEPTH(4), .AW(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .count(count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge: drive, check mid-cycle, advance model, clock.
   task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
      bit          emp;
      bit          byp;
      bit          ev;
      bit          acc;
      logic [63:0] hd;
      in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
      #4;
      emp = (q.size() == 0);
      byp = BYP && emp && iv && !fl;
      ev  = !emp || byp;
      hd  = !emp ? q[0] : (byp ? {pc, ins} : 64'h0);
      check("in_ready", {63'h0, in_ready}, {63'h0, q.size() < 4});
      check("out_valid", {63'h0, out_valid}, {63'h0, ev});
      check("out_pc", {32'h0, out_pc}, {32'h0, hd[63:32]});
      check("out_instr", {32'h0, out_instr}, {32'h0, hd[31:0]});
      check("count", {61'h0, count}, 64'(q.size()));
      if (fl) q.delete();
      else begin
         acc = iv && (q.size() < 4);
         if (ev && ordy && !emp) void'(q.pop_front());
         if (acc && !(byp && ordy)) q.push_back({pc, ins});
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] pcn;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_instr = '0;

      // reset between edges, checked before any clock edge
      #2 reset = 1'b1;
      #1;
      check("rst_valid", {63'h0, out_valid}, 64'h0);
      check("rst_count", {61'h0, count}, 64'h0);
      check("rst_ready", {63'h0, in_ready}, 64'h1);
      check("rst_pc", {32'h0, out_pc}, 64'h0);
      @(posedge clk); #1 reset = 1'b0;

      // fill then drain
      for (int i = 0; i < 4; i++) cycle(1, 32'h3000 + 32'(4*i), 32'hA000 + 32'(i), 0, 0);
      check("fill_count", {61'h0, count}, 64'h4);
      check("fill_ready", {63'h0, in_ready}, 64'h0);
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
      check("drain_count", {61'h0, count}, 64'h0);

      // steady state across pointer wrap
      cycle(1, 32'h3200, 32'hB000, 0, 0);
      cycle(1, 32'h3204, 32'hB001, 0, 0);
      for (int i = 2; i < 12; i++) cycle(1, 32'h3200 + 32'(4*i), 32'hB000 + 32'(i), 1, 0);
      check("steady_count", {61'h0, count}, 64'h2);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

      // flush with a same-cycle enqueue
      for (int i = 0; i < 3; i++) cycle(1, 32'h3400 + 32'(4*i), 32'hC000 + 32'(i), 0, 0);
      cycle(1, 32'h3100, 32'hDEAD, 1, 1);
      check("flush_count", {61'h0, count}, 64'h0);
      check("flush_valid", {63'h0, out_valid}, 64'h0);
      cycle(0, 0, 0, 1, 0);

      // full with out_ready: head leaves, incoming rejected
      for (int i = 0; i < 4; i++) cycle(1, 32'h3500 + 32'(4*i), 32'hE000 + 32'(i), 0, 0);
      cycle(1, 32'h3600, 32'hEEEE, 1, 0);
      check("full_deq_count", {61'h0, count}, 64'h3);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

      // enqueue into empty with out_ready
      cycle(1, 32'h3000, 32'hF000, 1, 0);
      if (BYP) check("byp_count", {61'h0, count}, 64'h0);
      else     check("nobyp_count", {61'h0, count}, 64'h1);
      cycle(0, 0, 0, 1, 0);

      // reset mid-stream, checked before the next edge
      cycle(1, 32'h3700, 32'h1, 0, 0);
      cycle(1, 32'h3704, 32'h2, 0, 0);
      in_valid = 1'b0; reset = 1'b1;
      #1;
      check("midrst_count", {61'h0, count}, 64'h0);
      check("midrst_valid", {63'h0, out_valid}, 64'h0);
      check("midrst_pc", {32'h0, out_pc}, 64'h0);
      q.delete();
      @(posedge clk); #1 reset = 1'b0;

      // random traffic
      pcn = 32'h4000;
      for (int i = 0; i < 400; i++) begin
         logic iv, ordy, fl;
         iv   = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 19) == 0);
         cycle(iv, pcn, $urandom, ordy, fl);
         pcn = pcn + 32'h4;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
